// File: rtl/mem_controller.sv
// Byte-serial RAM/IO port sequencer shared by instruction fetch and the load/store buffer.
// Serializes word fetches and LSB loads/stores into 1/2/4 byte cycles and returns assembled results.
module mem_controller #(
  parameter logic [31:0] IO_BASE      = 32'h00030000,
  parameter int          IO_SPAN_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic [4:0]  ls_oprand,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_data,
  output logic [1:0]  ls_ready,
  output logic [31:0] ls_mem_data
);
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

  state_t          state, state_n;
  logic [31:0]     base;
  logic [2:0]      nb, cnt, cm1, f3, ls_nb;
  logic [3:0][7:0] rbuf, sbuf;
  logic [31:0]     ext;
  logic            io_st, rsv, wr_q, ls_io, ls_blk;
  logic            take_ls, take_if, rd_step, rd_last, rd_done, st_step, st_block, st_done, ls_fin;

  assign ls_nb  = (ls_oprand[1:0] == 2'b00) ? 3'd1 : (ls_oprand[1:0] == 2'b01) ? 3'd2 : 3'd4;
  assign ls_io  = ls_addr[31:IO_SPAN_LOG2] == IO_BASE[31:IO_SPAN_LOG2];
  assign ls_blk = ls_oprand[3] && ls_io && io_buffer_full;
  assign cm1    = cnt - 3'd1;
  assign mem_wr = wr_q & rdy;

  always_comb begin
    state_n  = state;
    take_ls  = 1'b0;
    take_if  = 1'b0;
    rd_step  = 1'b0;
    rd_last  = 1'b0;
    rd_done  = 1'b0;
    st_step  = 1'b0;
    st_block = 1'b0;
    st_done  = 1'b0;
    case (state)
      IDLE: if (!flush) begin
        // A reserved cycle belongs to fetch; otherwise the LSB always wins.
        if (rsv)                             take_if = if_req;
        else if (ls_ready[0] && ls_oprand[4]) take_ls = 1'b1;
        else                                  take_if = if_req;
        if (take_ls)      state_n = ls_oprand[3] ? STORE : LOAD;
        else if (take_if) state_n = FETCH;
      end
      FETCH, LOAD: begin
        if (flush)            state_n = IDLE;
        else if (cnt < nb)    rd_step = 1'b1;
        else if (cnt == nb)   rd_last = 1'b1;
        else begin
          rd_done = 1'b1;
          state_n = IDLE;
        end
      end
      STORE: begin
        if (cnt == nb) begin
          st_done = 1'b1;
          state_n = IDLE;
        end else if (io_st && io_buffer_full) st_block = 1'b1;
        else                                  st_step  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    ls_fin = st_done || (rd_done && state == LOAD);
  end

  always_comb begin
    case (f3)
      3'b000:  ext = {{24{rbuf[0][7]}}, rbuf[0]};
      3'b001:  ext = {{16{rbuf[1][7]}}, rbuf[1], rbuf[0]};
      3'b100:  ext = {24'd0, rbuf[0]};
      3'b101:  ext = {16'd0, rbuf[1], rbuf[0]};
      default: ext = rbuf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_a       <= '0;
      mem_dout    <= '0;
      wr_q        <= 1'b0;
      if_done     <= 1'b0;
      if_data     <= '0;
      ls_ready    <= '0;
      ls_mem_data <= '0;
      base        <= '0;
      nb          <= '0;
      cnt         <= '0;
      f3          <= '0;
      rbuf        <= '0;
      sbuf        <= '0;
      io_st       <= 1'b0;
      rsv         <= 1'b0;
    end else if (rdy) begin
      state       <= state_n;
      if_done     <= 1'b0;
      ls_ready[1] <= 1'b0;
      // Fetch still waiting when an LSB op retires gets the next IDLE slot.
      rsv         <= ls_fin && if_req;
      ls_ready[0] <= (state_n == IDLE) && !(ls_fin && if_req);
      if (take_ls) begin
        base     <= ls_addr;
        nb       <= ls_nb;
        f3       <= ls_oprand[2:0];
        sbuf     <= ls_data;
        io_st    <= ls_io;
        mem_a    <= ls_addr;
        mem_dout <= ls_data[7:0];
        wr_q     <= ls_oprand[3] && !ls_blk;
        cnt      <= ls_blk ? 3'd0 : 3'd1;
      end
      if (take_if) begin
        base  <= if_addr;
        nb    <= 3'd4;
        f3    <= 3'b010;
        io_st <= 1'b0;
        mem_a <= if_addr;
        cnt   <= 3'd1;
      end
      if (rd_step) begin
        mem_a          <= base + {29'd0, cnt};
        rbuf[cm1[1:0]] <= mem_din;
        cnt            <= cnt + 3'd1;
      end
      if (rd_last) begin
        rbuf[cm1[1:0]] <= mem_din;
        cnt            <= cnt + 3'd1;
      end
      if (rd_done) begin
        if (state == FETCH) begin
          if_done <= 1'b1;
          if_data <= rbuf;
        end else begin
          ls_ready[1] <= 1'b1;
          ls_mem_data <= ext;
        end
      end
      if (st_step) begin
        mem_a    <= base + {29'd0, cnt};
        mem_dout <= sbuf[cnt[1:0]];
        wr_q     <= 1'b1;
        cnt      <= cnt + 3'd1;
      end
      if (st_block) wr_q <= 1'b0;
      if (st_done) begin
        wr_q        <= 1'b0;
        ls_ready[1] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: byte-level memory model, expectation queues, per-cycle checker.
module tb_mem_controller;
  logic        clk = 1'b0;
  logic        rst, rdy, flush, mem_wr, io_buffer_full, if_req, if_done;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a, if_addr, if_data, ls_addr, ls_data, ls_mem_data;
  logic [4:0]  ls_oprand;
  logic [1:0]  ls_ready;

  int checks = 0;
  int errors = 0;
  int n_wr = 0, n_ifd = 0, n_lsd = 0;

  typedef struct packed {logic [31:0] a; logic [7:0] d;} wr_t;
  typedef struct packed {logic ld; logic [31:0] d;} lsr_t;

  logic [7:0]  mem [logic [31:0]];
  wr_t         wr_exp[$];
  wr_t         wlog[$];
  lsr_t        ls_exp[$];
  logic [31:0] if_exp[$];
  logic [31:0] trace[$];

  always #5 clk = ~clk;

  mem_controller dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_oprand(ls_oprand), .ls_addr(ls_addr), .ls_data(ls_data),
    .ls_ready(ls_ready), .ls_mem_data(ls_mem_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic int nbytes(input logic [2:0] f);
    return f[1] ? 4 : (f[0] ? 2 : 1);
  endfunction

  // Load result from the byte memory: little-endian gather, then extend.
  function automatic logic [31:0] load_val(input logic [2:0] f, input logic [31:0] a);
    logic [31:0] w;
    int n;
    w = '0;
    n = nbytes(f);
    for (int i = 0; i < n; i++) w[8*i +: 8] = rd(a + 32'(i));
    if (!f[2] && n < 4 && w[8*n-1]) w = w | (32'hFFFF_FFFF << (8*n));
    return w;
  endfunction

  function automatic logic in_io(input logic [31:0] a);
    return (a >> 3) == (32'h0003_0000 >> 3);
  endfunction

  // mem_din follows the address presented during the preceding cycle.
  always @(negedge clk) mem_din = rd(mem_a);

  always @(posedge clk) begin : cmp
    wr_t  e;
    wr_t  o;
    lsr_t r;
    #1;
    if (!rst) begin
      chk("done_exclusive", 32'(if_done & ls_ready[1]), 0);
      if (mem_wr) begin
        n_wr++;
        o.a = mem_a;
        o.d = mem_dout;
        wlog.push_back(o);
        chk("write_expected", 32'(wr_exp.size() > 0), 1);
        if (wr_exp.size() > 0) begin
          e = wr_exp.pop_front();
          chk("wr_addr", mem_a, e.a);
          chk("wr_data", 32'(mem_dout), 32'(e.d));
        end
        if (in_io(mem_a)) chk("io_gate", 32'(io_buffer_full), 0);
        mem[mem_a] = mem_dout;
      end
      if (if_done) begin
        n_ifd++;
        chk("if_done_expected", 32'(if_exp.size() > 0), 1);
        if (if_exp.size() > 0) chk("if_data", if_data, if_exp.pop_front());
      end
      if (ls_ready[1]) begin
        n_lsd++;
        chk("ls_done_expected", 32'(ls_exp.size() > 0), 1);
        if (ls_exp.size() > 0) begin
          r = ls_exp.pop_front();
          if (r.ld) chk("ls_mem_data", ls_mem_data, r.d);
        end
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (ls_ready[0] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 32'(t < 50), 1);
  endtask

  task automatic ls_issue(input bit st, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input bit exp_done);
    lsr_t r;
    wr_t  w;
    wait_idle();
    if (exp_done) begin
      if (st) begin
        for (int i = 0; i < nbytes(f); i++) begin
          w.a = a + 32'(i);
          w.d = d[8*i +: 8];
          wr_exp.push_back(w);
        end
        r.ld = 1'b0;
        r.d  = '0;
      end else begin
        r.ld = 1'b1;
        r.d  = load_val(f, a);
      end
      ls_exp.push_back(r);
    end
    ls_oprand = {1'b1, st, f};
    ls_addr   = a;
    ls_data   = d;
    @(negedge clk);
    ls_oprand = '0;
  endtask

  // Returns cycles after the accepting edge at which ls_ready[1] was seen.
  task automatic wait_ls_done(input int start, output int lat);
    lat = start;
    trace.delete();
    while (ls_ready[1] !== 1'b1 && lat < 60) begin
      trace.push_back(mem_a);
      @(negedge clk);
      lat++;
    end
    chk("ls_done_timeout", 32'(lat < 60), 1);
  endtask

  task automatic load_case(input string nm, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] want, input int want_lat);
    int lat;
    ls_issue(1'b0, f, a, '0, 1'b1);
    wait_ls_done(0, lat);
    chk({nm, "_lat"}, lat, want_lat);
    chk({nm, "_data"}, ls_mem_data, want);
  endtask

  initial begin
    int lat, f, w0, d0;
    logic [31:0] fw;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0; ls_oprand = '0; ls_addr = '0; ls_data = '0;
    mem[32'h1000] = 8'h11; mem[32'h1001] = 8'h22; mem[32'h1002] = 8'h33; mem[32'h1003] = 8'h44;
    mem[32'h20]   = 8'h80; mem[32'h40]   = 8'h01; mem[32'h41]   = 8'h80;
    mem[32'h200]  = 8'h93; mem[32'h201]  = 8'h00; mem[32'h202]  = 8'h10; mem[32'h203]  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_flags", 32'({mem_wr, if_done, ls_ready}), 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_ls_mem_data", ls_mem_data, 0);
    chk("rst_mem_dout", 32'(mem_dout), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(ls_ready[0]), 1);

    // LW: address walk, latency, little-endian assembly
    ls_issue(1'b0, 3'b010, 32'h1000, '0, 1'b1);
    wait_ls_done(0, lat);
    chk("lw_lat", lat, 5);
    chk("lw_data", ls_mem_data, 32'h4433_2211);
    for (int k = 0; k < 4; k++) chk("lw_addr_walk", trace[k], 32'h1000 + 32'(k));

    load_case("lb",  3'b000, 32'h20, 32'hFFFF_FF80, 2);
    load_case("lbu", 3'b100, 32'h20, 32'h0000_0080, 2);
    load_case("lh",  3'b001, 32'h40, 32'hFFFF_8001, 3);
    load_case("lhu", 3'b101, 32'h40, 32'h0000_8001, 3);
    load_case("lw_wrap", 3'b010, 32'hFFFF_FFFE, load_val(3'b010, 32'hFFFF_FFFE), 5);
    chk("wrap_addr", trace[2], 32'h0);

    // SH: two writes, done two cycles after acceptance; then read back
    wlog.delete();
    ls_issue(1'b1, 3'b001, 32'h100, 32'h0000_ABCD, 1'b1);
    wait_ls_done(0, lat);
    chk("sh_lat", lat, 2);
    chk("sh_nwr", 32'(wlog.size()), 2);
    if (wlog.size() == 2) begin
      chk("sh_w0", {wlog[0].a[23:0], wlog[0].d}, 32'h0001_00CD);
      chk("sh_w1", {wlog[1].a[23:0], wlog[1].d}, 32'h0001_01AB);
    end
    load_case("lhu_after_sh", 3'b101, 32'h100, 32'h0000_ABCD, 3);

    // SB into the IO window while its buffer is full for three edges
    io_buffer_full = 1'b1;
    w0 = n_wr;
    ls_issue(1'b1, 3'b000, 32'h0003_0000, 32'h0000_00E7, 1'b1);
    chk("io_hold0", 32'(mem_wr), 0);
    @(negedge clk);
    chk("io_hold1", 32'(mem_wr), 0);
    @(negedge clk);
    chk("io_hold2", 32'(mem_wr), 0);
    io_buffer_full = 1'b0;
    wait_ls_done(2, lat);
    chk("io_sb_lat", lat, 4);
    chk("io_sb_nwr", n_wr - w0, 1);

    // Simultaneous fetch and LSB request: LSB first, then a reserved fetch slot
    wait_idle();
    fw = load_val(3'b010, 32'h200);
    if_exp.push_back(fw);
    d0 = n_ifd;
    ls_exp.push_back('{ld: 1'b1, d: load_val(3'b010, 32'h1000)});
    if_req = 1'b1; if_addr = 32'h200;
    ls_oprand = {1'b1, 1'b0, 3'b010}; ls_addr = 32'h1000;
    @(negedge clk);
    ls_oprand = '0;
    wait_ls_done(0, lat);
    chk("arb_ls_lat", lat, 5);
    chk("arb_no_fetch_yet", n_ifd - d0, 0);
    chk("arb_reserved_ready", 32'(ls_ready[0]), 0);
    f = 0;
    while (if_done !== 1'b1 && f < 40) begin
      @(negedge clk);
      f++;
      if (f == 1) chk("arb_fetch_busy", 32'(ls_ready[0]), 0);
    end
    if_req = 1'b0;
    chk("arb_fetch_lat", f, 6);
    chk("arb_if_data", if_data, 32'h0010_0093);

    // Flush on cycle 2 of a fetch: no if_done, IDLE next cycle
    wait_idle();
    d0 = n_ifd;
    if_req = 1'b1; if_addr = 32'h1000;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_fetch_idle", 32'(ls_ready[0]), 1);
    repeat (8) @(negedge clk);
    chk("flush_fetch_no_done", n_ifd - d0, 0);

    // Flush on cycle 2 of SW: store still commits all four bytes
    w0 = n_wr;
    ls_issue(1'b1, 3'b010, 32'h180, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_ls_done(2, lat);
    chk("flush_sw_lat", lat, 4);
    chk("flush_sw_nwr", n_wr - w0, 4);

    // Request in a flush cycle while IDLE is ignored
    wait_idle();
    d0 = n_lsd;
    flush = 1'b1;
    ls_oprand = {1'b1, 1'b0, 3'b010}; ls_addr = 32'h1000;
    @(negedge clk);
    flush = 1'b0; ls_oprand = '0;
    chk("flush_idle_ignored", 32'(ls_ready[0]), 1);
    repeat (7) @(negedge clk);
    chk("flush_idle_no_done", n_lsd - d0, 0);

    // rdy low freezes a load for two edges
    ls_issue(1'b0, 3'b001, 32'h40, '0, 1'b1);
    rdy = 1'b0;
    @(negedge clk);
    chk("freeze_a1", mem_a, 32'h40);
    @(negedge clk);
    chk("freeze_a2", mem_a, 32'h40);
    rdy = 1'b1;
    wait_ls_done(2, lat);
    chk("freeze_lat", lat, 5);
    chk("freeze_data", ls_mem_data, 32'hFFFF_8001);

    // Reset in the middle of a load
    d0 = n_lsd;
    ls_issue(1'b0, 3'b010, 32'h1000, '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_flags", 32'({mem_wr, if_done, ls_ready}), 0);
    chk("midrst_data", ls_mem_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(ls_ready[0]), 1);
    repeat (6) @(negedge clk);
    chk("midrst_no_done", n_lsd - d0, 0);

    chk("wr_exp_drained", 32'(wr_exp.size()), 0);
    chk("ls_exp_drained", 32'(ls_exp.size()), 0);
    chk("if_exp_drained", 32'(if_exp.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end
endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Sequences the single byte-wide RAM/IO port between the instruction fetch unit and the load/store buffer.
- Accepts a word fetch request or one LSB memory op at a time.
- Serializes the access into 1/2/4 byte-cycles and returns the assembled, sign-/zero-extended result with a one-cycle done pulse.
- Gates writes to the IO window on io_buffer_full and handles pipeline flush.

Parameters:
IO_BASE, 32'h00030000, base address of memory-mapped IO window
IO_SPAN_LOG2, 3, IO window is IO_BASE .. IO_BASE+2^IO_SPAN_LOG2-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state
flush  in  1  mispredict flush, one-cycle pulse
mem_din  in  8  RAM/IO read byte; reflects the address driven on mem_a in the previous cycle
mem_dout  out  8  write byte
mem_a  out  32  byte address
mem_wr  out  1  1=write, 0=read
io_buffer_full  in  1  IO write buffer full
if_req  in  1  fetch request, level, held until if_done or flush
if_addr  in  32  fetch address, stable while if_req
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word, little-endian
ls_oprand  in  5  {valid, op[3:0]}; op[3]=store, op[2:0]=funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
ls_addr  in  32  effective address
ls_data  in  32  store data (low bytes used)
ls_ready  out  2  [0]=idle, next ls_oprand accepted; [1]=op done pulse
ls_mem_data  out  32  load result, valid with ls_ready[1]

Behaviour:
- All outputs are registered. Reset values: every output 0, state IDLE, priority bit = LSB.
- ls_ready[0] rises at the first edge after reset deasserts.
- rdy low: no state or register changes; mem_wr output is ANDed with rdy.
- States:
  - IDLE
  - FETCH: 4-byte read
  - LOAD: N-byte read
  - STORE: N-byte write
- N = 1/2/4 from op[1:0].
- Arbitration in IDLE:
  - ls_oprand[4] always wins; the LSB pulse is never dropped while ls_ready[0]=1.
  - If if_req is pending when an LSB op completes, ls_ready[0] is held 0 for the next IDLE cycle and FETCH is granted. This gives round-robin fairness.
  - ls_ready[0]=0 in every non-IDLE state and in that reserved cycle.
- Read sequencing (FETCH/LOAD), accepting edge E0:
  - At E0: mem_a<=addr.
  - At Ek (k=1..N-1): mem_a<=addr+k; capture mem_din as byte k-1.
  - At EN: capture byte N-1.
  - At E(N+1): done pulse + data; return to IDLE.
  - Done is visible N+1 cycles after E0: LW 5, LH 3, LB 2.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Write sequencing (STORE), accepting edge E0:
  - At E0: mem_a<=addr, mem_dout<=byte0, mem_wr<=1.
  - At Ek: write byte k.
  - At EN: mem_wr<=0, ls_ready[1]<=1; return to IDLE.
  - SW done visible 4 cycles after E0; SB 1 cycle after E0.
- IO gating: for a store whose address is in the IO window, any byte edge with io_buffer_full=1 holds mem_wr=0 and the byte counter. That byte is retried on the next cycle.
- Flush:
  - In FETCH or LOAD: abort to IDLE next edge; no done pulse; partial data discarded.
  - In STORE: completes normally (the store is committed).
  - In IDLE: any request in the flush cycle is ignored.
  - Flush during the reserved-fetch cycle drops the reservation.
- Address arithmetic is 32-bit wrap-around.
- if_done and ls_ready[1] are never high in the same cycle.
- Reset mid-operation: immediate return to IDLE; mem_wr=0; no done pulse.

Test Plan:
1. Reset, then LW at 0x1000 with bytes 11,22,33,44 -> mem_a sequence 0x1000..0x1003; ls_ready[1]=1 five cycles after acceptance; ls_mem_data=0x44332211.
2. LB at 0x20 returning 0x80 -> 0xFFFFFF80. LBU -> 0x00000080. LH 0x8001 -> 0xFFFF8001.
3. SH data 0xABCD at 0x100 -> mem_wr=1 two cycles: (0x100, CD), (0x101, AB); ls_ready[1] two cycles after acceptance.
4. SB to 0x30000 with io_buffer_full=1 for 3 cycles -> no write until the buffer clears; then a single write of the byte; done one cycle later.
5. if_req and ls_oprand in the same IDLE cycle -> LSB served first. After its done, ls_ready[0] stays 0 for one cycle; FETCH runs; if_done with the correct word.
6. Flush on cycle 2 of FETCH -> no if_done; IDLE next cycle. Flush on cycle 2 of SW -> all 4 bytes written and ls_ready[1] still pulses.
